uart_rx_frame_controller: RTL
=============================

# uart_rx_frame_controller

Sequencing controller for the UART receive deserializer. It runs a frame state machine from the deserializer's status strobes and checks stop and parity bits. Accepted bytes are buffered in a small FIFO with a valid/ready consumer handshake, and the block keeps sticky overflow and saturating error counters. It sits between the Rx deserializer/FSM and the host-side consumer.

## Interface
- DATA_WIDTH, 8, width of a received character
- FIFO_DEPTH, 4, FIFO entries; power of two, ≥2
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd
- TIMEOUT_CYCLES, 2048, max clk cycles in RECEIVE before abort
- ERR_CNT_WIDTH, 8, width of each error counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rx_enable  in  1  gate for starting new frames
- data_is_available  in  1  deserializer is sampling a frame (level)
- data_is_valid  in  1  one-cycle pulse: all data bits captured
- received_data  in  DATA_WIDTH  deserialized character, stable when data_is_valid=1
- parity_bit  in  1  sampled parity bit, stable when data_is_valid=1
- stop_bit  in  1  sampled stop bit, stable when data_is_valid=1
- out_ready  in  1  consumer accepts head entry
- clear_status  in  1  clears overflow and counters
- out_valid  out  1  FIFO non-empty
- out_data  out  DATA_WIDTH  FIFO head character
- out_parity_err  out  1  parity error tag of head entry
- overflow  out  1  sticky: frame dropped on full FIFO
- framing_err_count  out  ERR_CNT_WIDTH  saturating framing/timeout error count
- parity_err_count  out  ERR_CNT_WIDTH  saturating parity error count
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RECEIVE, CHECK, PUSH.
- IDLE→RECEIVE: rising edge of data_is_available, detected against a registered copy, while rx_enable=1. A rising edge with rx_enable=0 is ignored for the whole frame.
- RECEIVE→CHECK: data_is_valid=1. Register received_data, parity_bit and stop_bit.
- RECEIVE→IDLE: timeout counter reaches TIMEOUT_CYCLES-1 without data_is_valid. framing_err_count increments.
- CHECK→IDLE: stop_bit=0. The frame is discarded and framing_err_count increments.
- CHECK→PUSH: stop_bit=1. The parity error flag is XOR(data, parity_bit) ≠ PARITY_ODD. parity_err_count increments if the flag is set.
- PUSH→IDLE always. If the FIFO is not full, write {parity flag, data}. If it is full, drop the entry and set overflow.
- Full is evaluated before any same-cycle pop. A push when full is dropped even if out_ready pops that cycle.
- Pop occurs when out_valid & out_ready. Push and pop in the same cycle on a non-full, non-empty FIFO keep the count unchanged.
- Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the rest are equal. Empty = pointers equal.
- Counters saturate at all-ones.
- clear_status zeroes overflow and both counters. It takes precedence over a same-cycle increment or set.
- data_is_valid outside RECEIVE is ignored.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, out_parity_err 0, overflow 0, both counters 0, busy 0, FIFO pointers 0.
- data_is_valid is high in cycle N. CHECK is in N+1, PUSH in N+2, and out_valid=1 from N+3 when the FIFO was empty.
- Errors are visible one cycle after the deciding state. Framing error: counter updated in N+2. Parity error: counter updated in N+2.
- out_data and out_parity_err are registered FIFO head, valid whenever out_valid=1. The next entry is presented the cycle after a pop.
- Reset asserted mid-frame returns the FSM to IDLE immediately and empties the FIFO. The frame in progress is lost.
- Back-to-back frames: a new data_is_available rise during CHECK or PUSH is ignored. The deserializer guarantees ≥1 bit-period gap, which is ≫3 clk cycles.

## Configuration
- RX_PARITY_CHECK_EN defined: parity is checked as above, and parity_err_count and out_parity_err are live.
- RX_PARITY_CHECK_EN undefined: parity_bit is ignored, out_parity_err ties to 0, parity_err_count ties to 0, and FIFO entries are DATA_WIDTH wide.

## Structure
- Shared package uart_pkg holds the FSM state enum (rx_ctrl_state_t, 2-bit encoding) and PARITY_EVEN/PARITY_ODD constants.
- One sub-module: uart_rx_fifo, a synchronous FIFO with registered head, full/empty flags and the push-when-full-drops rule.
- The FSM, checks and counters live in the top level.

## Test plan
- Frame 0xA5 with parity 0 and stop 1 (even, PARITY_ODD=0) → out_valid=1 three cycles after data_is_valid, out_data=0xA5, out_parity_err=0, counters 0.
- Frame 0x01 with parity 0, stop 1 → entry stored with out_parity_err=1, parity_err_count=1. With the macro undefined → out_parity_err=0, count stays 0.
- Frame with stop 0 → no FIFO write, framing_err_count=1. data_is_available rise with no data_is_valid for 2048 cycles → IDLE, count=2.
- out_ready held 0, five good frames 0x10–0x14 (depth 4) → FIFO holds 0x10–0x13, overflow=1. A 5th push coinciding with a pop is still dropped. Draining yields 0x10..0x13 in order.
- 260 framing errors with ERR_CNT_WIDTH=8 → count saturates at 255. clear_status in the same cycle as an error → count 0.
- reset deasserted→asserted during RECEIVE with two FIFO entries → busy=0, out_valid=0, all outputs at reset values asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame FSM encoding and parity sense constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_PUSH    = 2'd3
  } rx_ctrl_state_t;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with a registered head; a push while full is dropped even if a pop happens the same cycle.
// Head appears one cycle after the push into an empty FIFO; the next entry appears one cycle after a pop.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic             full_o,
  input  logic             pop_rdy_i,
  output logic             pop_vld_o,
  output logic [WIDTH-1:0] pop_dat_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty, wr_en, rd_en;

  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty     = (wr_q == rd_q);
  assign wr_en     = push_vld_i && !full_o;
  assign rd_en     = pop_rdy_i && !empty;
  assign wr_d      = wr_q + (AW+1)'(wr_en);
  assign rd_d      = rd_q + (AW+1)'(rd_en);
  assign pop_vld_o = !empty;
  assign pop_dat_o = head_q;

  // Bypass the write data when it lands in the slot that becomes the head.
  always_comb begin
    head_d = mem_q[rd_d[AW-1:0]];
    if (wr_en && (wr_q[AW-1:0] == rd_d[AW-1:0])) head_d = push_dat_i;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_controller.sv
// UART Rx frame sequencer: stop/parity checks, output FIFO, sticky overflow and saturating error counters.
// Parity checking exists only with RX_PARITY_CHECK_EN defined; entry reaches out_valid 3 cycles after data_is_valid.
module uart_rx_frame_controller #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter bit          PARITY_ODD     = uart_pkg::PARITY_EVEN,
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  parameter int unsigned ERR_CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_enable,
  input  logic                     data_is_available,
  input  logic                     data_is_valid,
  input  logic [DATA_WIDTH-1:0]    received_data,
  input  logic                     parity_bit,
  input  logic                     stop_bit,
  input  logic                     out_ready,
  input  logic                     clear_status,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_parity_err,
  output logic                     overflow,
  output logic [ERR_CNT_WIDTH-1:0] framing_err_count,
  output logic [ERR_CNT_WIDTH-1:0] parity_err_count,
  output logic                     busy
);

  import uart_pkg::*;

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`ifdef RX_PARITY_CHECK_EN
  localparam int unsigned FIFO_W = DATA_WIDTH + 1;
`else
  localparam int unsigned FIFO_W = DATA_WIDTH;
`endif

  rx_ctrl_state_t            state_q, state_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic                      avail_q, rise, cap, frm_inc, push;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      stop_q, overflow_q, fifo_full;
  logic [ERR_CNT_WIDTH-1:0]  frm_cnt_q;
  logic [FIFO_W-1:0]         push_dat, head_dat;

  assign rise = data_is_available && !avail_q;
  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    cap     = 1'b0;
    frm_inc = 1'b0;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise && rx_enable) begin
          state_d = ST_RECEIVE;
          tmo_d   = '0;
        end
      end
      ST_RECEIVE: begin
        if (data_is_valid) begin
          state_d = ST_CHECK;
          cap     = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          frm_inc = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_CHECK: begin
        if (!stop_q) begin
          state_d = ST_IDLE;
          frm_inc = 1'b1;
        end else begin
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        state_d = ST_IDLE;
        push    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      avail_q    <= 1'b0;
      data_q     <= '0;
      stop_q     <= 1'b0;
      overflow_q <= 1'b0;
      frm_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      avail_q <= data_is_available;
      if (cap) begin
        data_q <= received_data;
        stop_q <= stop_bit;
      end
      if (clear_status)            overflow_q <= 1'b0;
      else if (push && fifo_full)  overflow_q <= 1'b1;
      if (clear_status)                      frm_cnt_q <= '0;
      else if (frm_inc && (frm_cnt_q != '1)) frm_cnt_q <= frm_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

`ifdef RX_PARITY_CHECK_EN
  logic                     par_q, perr_flag;
  logic [ERR_CNT_WIDTH-1:0] par_cnt_q;

  // data_q/par_q stay stable through CHECK and PUSH, so the flag is recomputed rather than stored.
  assign perr_flag = ((^data_q) ^ par_q) != PARITY_ODD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q     <= 1'b0;
      par_cnt_q <= '0;
    end else begin
      if (cap) par_q <= parity_bit;
      if (clear_status)
        par_cnt_q <= '0;
      else if ((state_q == ST_CHECK) && stop_q && perr_flag && (par_cnt_q != '1))
        par_cnt_q <= par_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  assign push_dat         = {perr_flag, data_q};
  assign out_data         = head_dat[DATA_WIDTH-1:0];
  assign out_parity_err   = head_dat[DATA_WIDTH];
  assign parity_err_count = par_cnt_q;
`else
  logic unused_parity;
  localparam bit UNUSED_PARITY_ODD = PARITY_ODD;
  assign unused_parity    = parity_bit ^ UNUSED_PARITY_ODD;
  assign push_dat         = data_q;
  assign out_data         = head_dat;
  assign out_parity_err   = 1'b0;
  assign parity_err_count = '0;
`endif

  uart_rx_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_vld_i (push),
    .push_dat_i (push_dat),
    .full_o     (fifo_full),
    .pop_rdy_i  (out_ready),
    .pop_vld_o  (out_valid),
    .pop_dat_o  (head_dat)
  );

  assign overflow          = overflow_q;
  assign framing_err_count = frm_cnt_q;

endmodule
